dcache_resp: RTL and testbench
==============================

// Module: dcache_resp
// PURPOSE
//  Responder end of the LSB->DCache request interface. Accepts one load/store at a
//  time from LSB (DC_sgn/DC_addr/DC_val/DC_opcode) and serialises it onto the
//  byte-wide RAM port. Returns a one-cycle done pulse to LSB (its DC_sgn_in) plus
//  the assembled, extended load value. Sits between LSB and the memory arbiter.
// PARAMETERS
//  IO_BASE  32'h0003_0000  addresses >= IO_BASE are I/O (see CONFIGURATION)
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  rdy          in   1   global enable; low = hold all state
//  LSB_sgn      in   1   request valid; held with fields stable until LSB_done
//  LSB_addr     in   32  byte address
//  LSB_val      in   32  store data (ignored for loads)
//  LSB_opcode   in   6   `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW (defines.v)
//  LSB_done     out  1   one-cycle completion pulse (-> LSB DC_sgn_in)
//  LSB_data     out  32  load result, valid while LSB_done=1
//  mem_din      in   8   RAM read byte
//  mem_dout     out  8   RAM write byte
//  mem_a        out  32  RAM byte address
//  mem_wr       out  1   1 = write mem_dout to mem_a this cycle
//  io_buffer_full in 1   I/O write FIFO full
//  jp_wrong     in   1   misprediction flush
// BEHAVIOUR
//  Reset: state IDLE; LSB_done=0, LSB_data=0, mem_a=0, mem_dout=0, mem_wr=0.
//  rdy=0: no state/register changes; mem_wr forced 0.
//  FSM IDLE -> {LOAD|STORE} -> DONE -> IDLE. All outputs registered.
//  IDLE: if LSB_sgn, latch addr/val/opcode, N = 1/2/4 bytes (B/H/W), idx=0.
//   Unrecognised opcode: no RAM access, go DONE with LSB_data=0.
//  LOAD: cycle k (k=0..N-1) drives mem_a=addr+k, mem_wr=0. RAM byte for address
//   driven in cycle t is valid on mem_din in cycle t+1; captured into bits
//   [8k+7:8k] (little-endian). Accept at cycle A -> LSB_done at A+N+2.
//  STORE: cycle k drives mem_a=addr+k, mem_dout=val[8k+7:8k], mem_wr=1.
//   Accept at A -> LSB_done at A+N+1. mem_wr never high outside STORE.
//  Extension at DONE: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as-is.
//   Stores report LSB_data=0.
//  DONE: LSB_done=1 exactly one cycle; next cycle IDLE, LSB_done=0. LSB_sgn in the
//   DONE cycle is ignored (LSB deasserts it on the done edge); no double accept.
//  Address arithmetic: addr+k is 32-bit wrap-around; no alignment check.
//  jp_wrong: LOAD in progress aborts to IDLE, no LSB_done, mem_wr=0. STORE in
//   progress completes all bytes (already committed) but its LSB_done is suppressed.
//   jp_wrong in IDLE blocks acceptance that cycle. jp_wrong in DONE kills the pulse.
//  rst mid-operation: immediate return to reset values; partial store not resumed.
// CONFIGURATION
//  DC_IO_STALL_EN defined: a STORE byte with addr+k >= IO_BASE is not issued
//   (mem_wr=0, idx held) while io_buffer_full=1; resumes when it clears. Loads
//   never stall. Latency grows by the stalled cycles.
//  Undefined: io_buffer_full ignored; stores never stall.
// TESTING
//  1 SW addr=0x100 val=0xDEADBEEF -> bytes EF,BE,AD,DE at 0x100..0x103, done at A+5.
//  2 LB from 0x100 (byte 0x80) -> LSB_data=0xFFFFFF80; LBU -> 0x00000080, done A+3.
//  3 LH 0x102 over DE AD -> 0xFFFFDEAD; LW 0x100 -> 0xDEADBEEF at A+6.
//  4 LSB_sgn held high across done -> exactly one done pulse, single RAM access seq.
//  5 jp_wrong 1 cycle into LW -> no done, mem_wr stays 0; during SW -> 4 writes, no done.
//  6 DC_IO_STALL_EN, SB 0x30000, io_buffer_full=1 for 3 cycles -> write, done 3 late.

Source files
------------

// File: rtl/dcache_resp_if.sv
// LSB <-> DCache request/response bundle plus the byte-wide RAM port.
// The slave modport is the dcache_resp side. The master modport is the
// environment side, which drives LSB requests, RAM read data and flush/IO status.
interface dcache_resp_if;
  logic        LSB_sgn;
  logic [31:0] LSB_addr;
  logic [31:0] LSB_val;
  logic [5:0]  LSB_opcode;
  logic        LSB_done;
  logic [31:0] LSB_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        jp_wrong;

  modport master (
    output LSB_sgn, LSB_addr, LSB_val, LSB_opcode,
    output mem_din, io_buffer_full, jp_wrong,
    input  LSB_done, LSB_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  LSB_sgn, LSB_addr, LSB_val, LSB_opcode,
    input  mem_din, io_buffer_full, jp_wrong,
    output LSB_done, LSB_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/dcache_resp.sv
// dcache_resp: serialises one LSB load/store at a time onto a byte-wide RAM
// port and returns a one-cycle done pulse with the extended load value.
// Optional feature macro: DC_IO_STALL_EN -- when defined, store bytes aimed at
// addresses >= IO_BASE wait while io_buffer_full is high. When undefined,
// io_buffer_full is ignored.
module dcache_resp #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  dcache_resp_if.slave bus
);

  // Opcode encoding shared with the LSB
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] val_reg, val_next;
  logic [2:0]  size_reg, size_next;    // access width in bytes: 1, 2 or 4
  logic        sext_reg, sext_next;
  // Store: bytes issued so far. Load: LOAD cycles elapsed (byte idx-1 is on mem_din).
  logic [2:0]  idx_reg, idx_next;
  logic        kill_reg, kill_next;    // flush seen during a store: drop its done pulse
  logic [31:0] asm_reg, asm_next;      // load bytes gathered so far
  logic [31:0] data_reg, data_next;
  logic        done_reg, done_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        mem_wr_reg, mem_wr_next;

  logic        dec_valid, dec_store, dec_sext;
  logic [2:0]  dec_size;
  logic [31:0] store_addr;
  logic [31:0] asm_cur;
  logic [2:0]  idx_m1;
  logic        stall_idle, stall_store;

  // Zero/sign extension of an assembled load word to 32 bits
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic s);
    logic [31:0] r;
    r = w;
    case (n)
      3'd1:    r = s ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
      3'd2:    r = s ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Opcode decode: width, direction and signedness of the incoming request
  always_comb begin
    dec_valid = 1'b1;
    dec_store = 1'b0;
    dec_sext  = 1'b0;
    dec_size  = 3'd1;
    case (bus.LSB_opcode)
      OP_LB:  dec_sext = 1'b1;
      OP_LH:  begin dec_size = 3'd2; dec_sext = 1'b1; end
      OP_LW:  dec_size = 3'd4;
      OP_LBU: dec_size = 3'd1;
      OP_LHU: dec_size = 3'd2;
      OP_SB:  dec_store = 1'b1;
      OP_SH:  begin dec_store = 1'b1; dec_size = 3'd2; end
      OP_SW:  begin dec_store = 1'b1; dec_size = 3'd4; end
      default: dec_valid = 1'b0;
    endcase
  end

  assign store_addr = addr_reg + {29'd0, idx_reg};

`ifdef DC_IO_STALL_EN
  // A store byte towards I/O space waits for room in the I/O write FIFO
  assign stall_idle  = (bus.LSB_addr >= IO_BASE) && bus.io_buffer_full;
  assign stall_store = (store_addr >= IO_BASE) && bus.io_buffer_full;
`else
  logic unused_io_cfg;
  assign unused_io_cfg = ^{IO_BASE, bus.io_buffer_full};
  assign stall_idle    = 1'b0;
  assign stall_store   = 1'b0;
`endif

  // Next-state and next-output logic for the request sequencer
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    val_next      = val_reg;
    size_next     = size_reg;
    sext_next     = sext_reg;
    idx_next      = idx_reg;
    kill_next     = kill_reg;
    asm_next      = asm_reg;
    data_next     = data_reg;
    mem_a_next    = mem_a_reg;
    mem_dout_next = mem_dout_reg;
    mem_wr_next   = 1'b0;
    done_next     = 1'b0;

    // Merge the byte currently on mem_din into its little-endian lane
    idx_m1  = idx_reg - 3'd1;
    asm_cur = asm_reg;
    if (idx_reg != 3'd0) begin
      asm_cur[{idx_m1[1:0], 3'b000} +: 8] = bus.mem_din;
    end

    case (state_reg)
      IDLE: begin
        if (bus.LSB_sgn && !bus.jp_wrong) begin
          addr_next = bus.LSB_addr;
          val_next  = bus.LSB_val;
          size_next = dec_size;
          sext_next = dec_sext;
          idx_next  = 3'd0;
          kill_next = 1'b0;
          asm_next  = 32'd0;
          if (!dec_valid) begin
            data_next  = 32'd0;
            done_next  = 1'b1;
            state_next = DONE;
          end else if (dec_store) begin
            state_next = STORE;
            if (!stall_idle) begin
              mem_a_next    = bus.LSB_addr;
              mem_dout_next = bus.LSB_val[7:0];
              mem_wr_next   = 1'b1;
              idx_next      = 3'd1;
            end
          end else begin
            state_next = LOAD;
            mem_a_next = bus.LSB_addr;
          end
        end
      end

      LOAD: begin
        if (bus.jp_wrong) begin
          state_next = IDLE;
        end else begin
          asm_next = asm_cur;
          idx_next = idx_reg + 3'd1;
          if (idx_reg == size_reg) begin
            data_next  = extend(asm_cur, size_reg, sext_reg);
            done_next  = 1'b1;
            state_next = DONE;
          end else if (idx_next < size_reg) begin
            mem_a_next = addr_reg + {29'd0, idx_next};
          end
        end
      end

      STORE: begin
        // Bytes already written cannot be recalled, so a flush only hides the pulse
        kill_next = kill_reg | bus.jp_wrong;
        if (idx_reg < size_reg) begin
          if (!stall_store) begin
            mem_a_next    = store_addr;
            mem_dout_next = val_reg[{idx_reg[1:0], 3'b000} +: 8];
            mem_wr_next   = 1'b1;
            idx_next      = idx_reg + 3'd1;
          end
        end else begin
          data_next = 32'd0;
          if (kill_next) begin
            state_next = IDLE;
          end else begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      val_reg      <= 32'd0;
      size_reg     <= 3'd0;
      sext_reg     <= 1'b0;
      idx_reg      <= 3'd0;
      kill_reg     <= 1'b0;
      asm_reg      <= 32'd0;
      data_reg     <= 32'd0;
      done_reg     <= 1'b0;
      mem_a_reg    <= 32'd0;
      mem_dout_reg <= 8'd0;
      mem_wr_reg   <= 1'b0;
    end else if (rdy) begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      val_reg      <= val_next;
      size_reg     <= size_next;
      sext_reg     <= sext_next;
      idx_reg      <= idx_next;
      kill_reg     <= kill_next;
      asm_reg      <= asm_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      mem_a_reg    <= mem_a_next;
      mem_dout_reg <= mem_dout_next;
      mem_wr_reg   <= mem_wr_next;
    end
  end

  // A held write is masked while stalled by rdy and issued once rdy returns.
  // A flush in the done cycle suppresses the pulse.
  assign bus.LSB_done = done_reg & ~bus.jp_wrong;
  assign bus.LSB_data = data_reg;
  assign bus.mem_a    = mem_a_reg;
  assign bus.mem_dout = mem_dout_reg;
  assign bus.mem_wr   = mem_wr_reg & rdy;

endmodule

// File: tb/tb_dcache_resp.sv
// Testbench for dcache_resp: LSB driver, byte RAM model and a scoreboard of
// expected load data / done latency checked whenever LSB_done pulses.
module tb_dcache_resp;
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          lat;
    int          start;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   rdy_wr_viol = 0;

  sb_item_t    sb[$];
  logic [39:0] wlog[$];             // {addr, byte} of each RAM write
  logic [7:0]  mem [logic [31:0]];

  dcache_resp_if bus ();

  dcache_resp dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // RAM model: write on mem_wr, registered read (data valid the next cycle)
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= rd(bus.mem_a);
  end

  // Monitor: log writes, pop the scoreboard on every done pulse
  always @(negedge clk) begin
    sb_item_t e;
    if (bus.mem_wr) wlog.push_back({bus.mem_a, bus.mem_dout});
    if (!rdy && bus.mem_wr) rdy_wr_viol++;
    if (bus.LSB_done) begin
      done_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        $display("txn %s data=%h lat=%0d", e.name, bus.LSB_data, cyc - e.start);
        if (bus.LSB_data !== e.data) begin
          bad++;
          $display("FAIL %s data: got %h required %h", e.name, bus.LSB_data, e.data);
        end
        total++;
        if ((cyc - e.start) !== e.lat) begin
          bad++;
          $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.start, e.lat);
        end
      end
    end
  end

  task automatic do_req(input string name, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] val, input logic [31:0] exp_data, input int lat,
                        input int full_n, input int rdy_gap, input bit jp_first);
    sb_item_t it;
    bit seen;
    @(posedge clk);
    #1;
    it.name  = name;
    it.data  = exp_data;
    it.lat   = lat;
    it.start = cyc;
    sb.push_back(it);
    bus.LSB_sgn    = 1'b1;
    bus.LSB_opcode = op;
    bus.LSB_addr   = addr;
    bus.LSB_val    = val;
    if (full_n > 0) begin
      bus.io_buffer_full = 1'b1;
      fork
        begin
          repeat (full_n) @(posedge clk);
          #1 bus.io_buffer_full = 1'b0;
        end
      join_none
    end
    if (rdy_gap > 0) begin
      fork
        begin
          @(posedge clk);
          #1 rdy = 1'b0;
          repeat (rdy_gap) @(posedge clk);
          #1 rdy = 1'b1;
        end
      join_none
    end
    if (jp_first) begin
      bus.jp_wrong = 1'b1;
      fork
        begin
          @(posedge clk);
          #1 bus.jp_wrong = 1'b0;
        end
      join_none
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.LSB_done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done in 60 cycles, required done", name);
      sb.delete();
    end
    @(posedge clk);
    #1 bus.LSB_sgn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.LSB_done, bus.LSB_data, bus.mem_a, bus.mem_dout, bus.mem_wr} !== 74'd0) begin
      bad++;
      $display("FAIL reset_outputs: got done=%b data=%h a=%h dout=%h wr=%b, required all 0",
               bus.LSB_done, bus.LSB_data, bus.mem_a, bus.mem_dout, bus.mem_wr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_store_word();
    logic [39:0] exp_w [4];
    exp_w[0] = {32'h100, 8'hEF};
    exp_w[1] = {32'h101, 8'hBE};
    exp_w[2] = {32'h102, 8'hAD};
    exp_w[3] = {32'h103, 8'hDE};
    wlog.delete();
    do_req("sw_100", OP_SW, 32'h100, 32'hDEADBEEF, 32'd0, 5, 0, 0, 0);
    total++;
    if (wlog.size() !== 4) begin
      bad++;
      $display("FAIL sw_100 write_count: got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wlog[i] !== exp_w[i]) begin
          bad++;
          $display("FAIL sw_100 write%0d: got %h required %h", i, wlog[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_load();
    do_req("lw_100",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 6, 0, 0, 0);
    do_req("lh_102",  OP_LH,  32'h102, 32'h0, 32'hFFFFDEAD, 4, 0, 0, 0);
    do_req("lhu_102", OP_LHU, 32'h102, 32'h0, 32'h0000DEAD, 4, 0, 0, 0);
    do_req("lb_103",  OP_LB,  32'h103, 32'h0, 32'hFFFFFFDE, 3, 0, 0, 0);
  endtask

  task automatic test_byte_ext();
    do_req("sb_100",  OP_SB,  32'h100, 32'h12345680, 32'd0, 2, 0, 0, 0);
    do_req("lb_100",  OP_LB,  32'h100, 32'h0, 32'hFFFFFF80, 3, 0, 0, 0);
    do_req("lbu_100", OP_LBU, 32'h100, 32'h0, 32'h00000080, 3, 0, 0, 0);
    do_req("lw_100b", OP_LW,  32'h100, 32'h0, 32'hDEADBE80, 6, 0, 0, 0);
    do_req("lb_101",  OP_LB,  32'h101, 32'h0, 32'hFFFFFFBE, 3, 0, 0, 0);
  endtask

  task automatic test_half();
    do_req("sh_200",  OP_SH,  32'h200, 32'hABCD7FFF, 32'd0, 3, 0, 0, 0);
    do_req("lh_200",  OP_LH,  32'h200, 32'h0, 32'h00007FFF, 4, 0, 0, 0);
    do_req("sh_202",  OP_SH,  32'h202, 32'h00008001, 32'd0, 3, 0, 0, 0);
    do_req("lw_200",  OP_LW,  32'h200, 32'h0, 32'h80017FFF, 6, 0, 0, 0);
    do_req("lh_202",  OP_LH,  32'h202, 32'h0, 32'hFFFF8001, 4, 0, 0, 0);
  endtask

  task automatic test_wrap();
    wlog.delete();
    do_req("sw_wrap", OP_SW, 32'hFFFFFFFE, 32'hCAFEF00D, 32'd0, 5, 0, 0, 0);
    total++;
    if (wlog.size() !== 4 || wlog[2] !== {32'h0, 8'hFE} || wlog[3] !== {32'h1, 8'hCA}) begin
      bad++;
      $display("FAIL sw_wrap writes: got n=%0d w2=%h w3=%h required n=4 w2=%h w3=%h",
               wlog.size(), wlog[2], wlog[3], {32'h0, 8'hFE}, {32'h1, 8'hCA});
    end
    do_req("lw_wrap", OP_LW, 32'hFFFFFFFE, 32'h0, 32'hCAFEF00D, 6, 0, 0, 0);
  endtask

  task automatic test_bad_opcode();
    wlog.delete();
    do_req("bad_op", 6'd63, 32'h100, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 0);
    total++;
    if (wlog.size() !== 0) begin
      bad++;
      $display("FAIL bad_op writes: got %0d required 0", wlog.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    wlog.delete();
    do_req("sw_hold", OP_SW, 32'h180, 32'h01020304, 32'd0, 5, 0, 0, 0);
    do_req("lw_hold", OP_LW, 32'h180, 32'h0, 32'h01020304, 6, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (done_cnt - d0 !== 2 || wlog.size() !== 4) begin
      bad++;
      $display("FAIL hold_across_done: got dones=%0d writes=%0d required dones=2 writes=4",
               done_cnt - d0, wlog.size());
    end
  endtask

  task automatic test_jp_wrong();
    int d0;
    d0 = done_cnt;
    wlog.delete();
    @(posedge clk);
    #1;
    bus.LSB_sgn = 1'b1; bus.LSB_opcode = OP_LW; bus.LSB_addr = 32'h100; bus.LSB_val = 32'h0;
    @(posedge clk);
    #1 bus.jp_wrong = 1'b1;
    @(posedge clk);
    #1 begin bus.jp_wrong = 1'b0; bus.LSB_sgn = 1'b0; end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0 || wlog.size() !== 0) begin
      bad++;
      $display("FAIL jp_lw_abort: got dones=%0d writes=%0d required 0 and 0",
               done_cnt - d0, wlog.size());
    end
    bus.LSB_sgn = 1'b1; bus.LSB_opcode = OP_SW; bus.LSB_addr = 32'h300; bus.LSB_val = 32'h11223344;
    @(posedge clk);
    #1 bus.jp_wrong = 1'b1;
    @(posedge clk);
    #1 begin bus.jp_wrong = 1'b0; bus.LSB_sgn = 1'b0; end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0 || wlog.size() !== 4) begin
      bad++;
      $display("FAIL jp_sw_kill: got dones=%0d writes=%0d required 0 and 4",
               done_cnt - d0, wlog.size());
    end
    do_req("lw_300", OP_LW, 32'h300, 32'h0, 32'h11223344, 6, 0, 0, 0);
    do_req("lw_jp_idle", OP_LW, 32'h100, 32'h0, 32'hDEADBE80, 7, 0, 0, 1);
  endtask

  task automatic test_rdy();
    wlog.delete();
    rdy_wr_viol = 0;
    do_req("sw_rdy", OP_SW, 32'h500, 32'hA1B2C3D4, 32'd0, 7, 0, 2, 0);
    total++;
    if (wlog.size() !== 4 || rdy_wr_viol !== 0) begin
      bad++;
      $display("FAIL sw_rdy writes: got n=%0d wr_while_rdy0=%0d required 4 and 0",
               wlog.size(), rdy_wr_viol);
    end
    do_req("lw_rdy", OP_LW, 32'h500, 32'h0, 32'hA1B2C3D4, 9, 0, 3, 0);
  endtask

  task automatic test_io_stall();
    wlog.delete();
`ifdef DC_IO_STALL_EN
    do_req("sb_io_stall", OP_SB, 32'h0003_0000, 32'h0000005A, 32'd0, 5, 3, 0, 0);
`else
    do_req("sb_io_nostall", OP_SB, 32'h0003_0000, 32'h0000005A, 32'd0, 2, 3, 0, 0);
`endif
    total++;
    if (wlog.size() !== 1 || wlog[0] !== {32'h0003_0000, 8'h5A}) begin
      bad++;
      $display("FAIL sb_io write: got n=%0d w0=%h required n=1 w0=%h",
               wlog.size(), wlog[0], {32'h0003_0000, 8'h5A});
    end
    do_req("sb_mem_full", OP_SB, 32'h104, 32'h00000077, 32'd0, 2, 3, 0, 0);
    do_req("lb_io_full",  OP_LB, 32'h0003_0000, 32'h0, 32'h0000005A, 3, 3, 0, 0);
    do_req("lbu_104",     OP_LBU, 32'h104, 32'h0, 32'h00000077, 3, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    int d0;
    d0 = done_cnt;
    wlog.delete();
    @(posedge clk);
    #1;
    bus.LSB_sgn = 1'b1; bus.LSB_opcode = OP_SW; bus.LSB_addr = 32'h400; bus.LSB_val = 32'h55667788;
    @(posedge clk);
    @(posedge clk);
    #1 begin rst = 1'b1; bus.LSB_sgn = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.LSB_done, bus.LSB_data, bus.mem_a, bus.mem_dout, bus.mem_wr} !== 74'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got done=%b a=%h dout=%h wr=%b, required all 0",
               bus.LSB_done, bus.mem_a, bus.mem_dout, bus.mem_wr);
    end
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0 || wlog.size() !== 2) begin
      bad++;
      $display("FAIL rst_mid_abort: got dones=%0d writes=%0d required 0 and 2",
               done_cnt - d0, wlog.size());
    end
  endtask

  initial begin
    bus.LSB_sgn        = 1'b0;
    bus.LSB_addr       = 32'd0;
    bus.LSB_val        = 32'd0;
    bus.LSB_opcode     = 6'd0;
    bus.io_buffer_full = 1'b0;
    bus.jp_wrong       = 1'b0;
    test_reset();
    test_store_word();
    test_load();
    test_byte_ext();
    test_half();
    test_wrap();
    test_bad_opcode();
    test_back_to_back();
    test_jp_wrong();
    test_rdy();
    test_io_stall();
    test_rst_mid();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
